instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage wrapped around the next-PC logic: holds the architectural PC register and runs a request/acknowledge read of instruction memory at that PC. It presents the fetched word and its decoded fields to the decode/control stage, and drives `pc` and `imm16` into the next-PC block. When the downstream stage accepts an instruction, it loads the next-PC block's result back into the PC. It halts with a fault on a misaligned next PC.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `next_pc`  in  32  next PC from the next-PC block (PC+4 or branch target).
- `pc`  out  32  current PC register; feeds next-PC block `pc_in`.
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  32  read address; equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  registered instruction.
- `inst_valid`  out  1  `inst` and its fields are valid.
- `inst_ready`  in  1  downstream accepts `inst` this cycle.
- `opcode`  out  6  `inst[31:26]`.
- `rs`  out  5  `inst[25:21]`.
- `rt`  out  5  `inst[20:16]`.
- `rd`  out  5  `inst[15:11]`.
- `shamt`  out  5  `inst[10:6]`.
- `funct`  out  6  `inst[5:0]`.
- `imm16`  out  16  `inst[15:0]`; feeds next-PC block.
- `fault`  out  1  sticky misaligned-PC fault.
- `fetch_count`  out  32  number of accepted instructions; wraps modulo 2^32.

## Operation
- States: IDLE, WAIT, HOLD, FAULT.
- IDLE:
  - All handshake outputs are 0.
  - Unconditional transition to WAIT.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `inst`<=`imem_rdata`, then go to HOLD.
  - Otherwise stay in WAIT. `pc` and `imem_addr` are held stable.
- HOLD:
  - `inst_valid`=1; `inst` is stable.
  - On `inst_ready`=1:
    - `pc`<=`next_pc` and `fetch_count`<=`fetch_count`+1.
    - If `next_pc[1:0]`!=0, go to FAULT; otherwise go to WAIT.
  - Otherwise stay in HOLD.
- FAULT:
  - `fault`=1, `imem_req`=0, `inst_valid`=0.
  - `pc` holds the misaligned value for debug.
  - Left only by reset.
- `imem_ack` is ignored in every state except WAIT.
- `inst_ready` is ignored in every state except HOLD.
- Field outputs are combinational slices of the `inst` register. They are meaningful only while `inst_valid`=1.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `inst`=0, `fetch_count`=0.
  - `imem_req`=0, `inst_valid`=0, `fault`=0.
- `imem_req`, `inst_valid` and `fault` are decoded from the state register. None of them depends combinationally on any input.
- First request:
  - Cycle 0: reset low, state IDLE.
  - Cycle 1: `imem_req`=1.
- Fetch latency: `imem_ack` in cycle N of WAIT gives `inst_valid`=1 in cycle N+1. Zero-wait memory means ack in the first WAIT cycle.
- Peak throughput: one instruction per 2 cycles (WAIT + HOLD), with ack and ready both immediate.
- `next_pc` is sampled only on the HOLD and `inst_ready` edge. The next-PC block is combinational on `pc` and `imm16`, both stable throughout HOLD.
- Reset mid-request abandons the outstanding read; a late `imem_ack` after reset falls in IDLE and is ignored.
- Reset has priority over a simultaneous `imem_ack` or `inst_ready`.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0 with no flag.

## Structure
- Shared include `fetch_defs.v` holds:
  - the 2-bit state encodings `FS_IDLE`/`FS_WAIT`/`FS_HOLD`/`FS_FAULT`;
  - the instruction field bit positions (opcode/rs/rt/rd/shamt/funct/imm16).
  - The decode stage reuses the field positions.
- One sub-module: `inst_fields`, a purely combinational splitter from `inst` to the field outputs.
- PC register, state register and counter live in `instruction_fetch`.
- `instruction_fetch` is instantiated alongside the next-PC block: `pc`->`pc_in`, `imm16`->`imm16`, `pc_out`->`next_pc`.

## Test plan
- Reset, zero-wait memory: `imem_ack`=1 every cycle, rdata=32'h2008_0005, `inst_ready`=1.
  - Addresses 0x0040_0000, 0x0040_0004, 0x0040_0008 on successive requests.
  - `opcode`=8, `rt`=8, `imm16`=5.
  - `fetch_count`=3 after the third accept.
- Memory wait states: hold `imem_ack`=0 for 3 cycles.
  - `imem_req` stays 1 and `imem_addr` stays at 0x0040_0000.
  - `inst_valid` rises exactly one cycle after the ack.
- Back-pressure: `inst_ready`=0 for 4 HOLD cycles.
  - `inst` and `pc` stay unchanged, `imem_req`=0, and the count does not increment.
- Branch: `next_pc`=0x0040_0014 on the accept edge.
  - The next request uses `imem_addr`=0x0040_0014.
- Misaligned: `next_pc`=0x0040_0016 on accept.
  - `fault`=1 next cycle, no further `imem_req`.
  - Reset then restores `pc`=0x0040_0000 and `fault`=0.
- Reset while in WAIT with ack pending: ack arriving one cycle after reset is ignored, `inst_valid` stays 0, and the request restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared definitions for the fetch stage: fetch FSM state
//               encodings and instruction field bit positions (the field
//               positions are also used by the decode stage).
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  // Fetch FSM state encoding (2-bit).
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_WAIT  = 2'd1;
  localparam fetch_state_t FS_HOLD  = 2'd2;
  localparam fetch_state_t FS_FAULT = 2'd3;

  // Instruction field bit positions.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/inst_fields.sv
`default_nettype none
// ============================================================================
// Module      : inst_fields
// Description : Purely combinational splitter from an instruction word to
//               its decoded fields.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fields
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign opcode = inst[OPCODE_MSB:OPCODE_LSB];
  assign rs     = inst[RS_MSB:RS_LSB];
  assign rt     = inst[RT_MSB:RT_LSB];
  assign rd     = inst[RD_MSB:RD_LSB];
  assign shamt  = inst[SHAMT_MSB:SHAMT_LSB];
  assign funct  = inst[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = inst[IMM16_MSB:IMM16_LSB];

endmodule : inst_fields
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Holds the PC, runs a req/ack read of
//               instruction memory, presents the registered instruction and
//               its fields downstream, and loads next_pc on accept. A
//               misaligned next PC parks the stage in a sticky fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  // Memory returns data in WAIT; downstream takes the word in HOLD.
  logic capture;
  logic accept;

  assign capture = (state_q == FS_WAIT) && imem_ack;
  assign accept  = (state_q == FS_HOLD) && inst_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a misaligned next PC ends in FAULT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE:  state_d = FS_WAIT;
      FS_WAIT:  if (imem_ack) state_d = FS_HOLD;
      FS_HOLD: begin
        if (inst_ready) begin
          state_d = (next_pc[1:0] != 2'b00) ? FS_FAULT : FS_WAIT;
        end
      end
      FS_FAULT: state_d = FS_FAULT;
      default:  state_d = FS_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    imem_req   = (state_q == FS_WAIT);
    inst_valid = (state_q == FS_HOLD);
    fault      = (state_q == FS_FAULT);
  end

  // PC, instruction register and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inst        <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      if (capture) begin
        inst <= imem_rdata;
      end
      if (accept) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // pc is only updated on accept, so it is stable for the whole WAIT.
  assign imem_addr = pc;

  inst_fields u_inst_fields (
    .inst   (inst),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch: directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        fault;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase of the current fetch transaction.
  // 0 = just out of reset, 1 = awaiting memory, 2 = holding word, 3 = faulted
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_outputs();
    check("imem_req",    {31'd0, imem_req},   {31'd0, m_phase == 1});
    check("inst_valid",  {31'd0, inst_valid}, {31'd0, m_phase == 2});
    check("fault",       {31'd0, fault},      {31'd0, m_phase == 3});
    check("pc",          pc,          m_pc);
    check("fetch_count", fetch_count, m_cnt);
    if (m_phase == 1) check("imem_addr", imem_addr, m_pc);
    if (m_phase == 2) begin
      check("inst",   inst,           m_inst);
      check("opcode", {26'd0, opcode}, (m_inst >> 26) & 32'h3F);
      check("rs",     {27'd0, rs},     (m_inst >> 21) & 32'h1F);
      check("rt",     {27'd0, rt},     (m_inst >> 16) & 32'h1F);
      check("rd",     {27'd0, rd},     (m_inst >> 11) & 32'h1F);
      check("shamt",  {27'd0, shamt},  (m_inst >> 6)  & 32'h1F);
      check("funct",  {26'd0, funct},  m_inst & 32'h3F);
      check("imm16",  {16'd0, imm16},  m_inst & 32'hFFFF);
    end
  endtask

  // One clock: drive inputs, check, advance model on the rising edge.
  task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                     input logic rdy, input logic [31:0] np);
    reset      = r;
    imem_ack   = a;
    imem_rdata = d;
    inst_ready = rdy;
    next_pc    = np;
    #1;
    check_outputs();
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_pc = RST_PC; m_inst = 32'd0; m_cnt = 32'd0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && a) begin
      m_inst = d; m_phase = 2;
    end else if (m_phase == 2 && rdy) begin
      m_pc = np; m_cnt = m_cnt + 1;
      m_phase = (np % 4 != 0) ? 3 : 1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0; next_pc = 32'd0;
    m_phase = 0; m_pc = RST_PC; m_inst = 32'd0; m_cnt = 32'd0;
    @(negedge clk);

    // Reset state.
    cyc(1, 1, 32'hDEAD_BEEF, 1, 32'h0);
    cyc(1, 0, 32'h0, 0, 32'h0);

    // Zero-wait memory, immediate ready, sequential PC.
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        check("zw_opcode", {26'd0, opcode}, 32'd8);
        check("zw_rt",     {27'd0, rt},     32'd8);
        check("zw_imm16",  {16'd0, imm16},  32'd5);
      end
      cyc(0, 1, 32'h2008_0005, 1, m_pc + 32'd4);
    end
    check("zw_count3", fetch_count, 32'd3);
    check("zw_pc", pc, 32'h0040_000C);

    // Memory wait states from reset.
    cyc(1, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 1, 32'h0);
    cyc(0, 1, 32'h8C43_1234, 0, 32'h0);
    check("ws_valid_rise", {31'd0, inst_valid}, 32'd1);

    // Back-pressure in HOLD.
    for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0, 32'h0);
    check("bp_count", fetch_count, 32'd0);

    // Branch taken on accept.
    cyc(0, 0, 32'h0, 1, 32'h0040_0014);
    check("br_addr", imem_addr, 32'h0040_0014);
    cyc(0, 1, 32'h1000_0003, 0, 32'h0);

    // Misaligned next PC -> fault, then reset recovers.
    cyc(0, 0, 32'h0, 1, 32'h0040_0016);
    check("mis_fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h0, 1, 32'h0040_0100);
    check("mis_pc_held", pc, 32'h0040_0016);
    cyc(1, 0, 32'h0, 0, 32'h0);
    check("rst_pc", pc, RST_PC);
    check("rst_fault", {31'd0, fault}, 32'd0);

    // Reset during WAIT; the late ack lands in the post-reset idle cycle.
    cyc(0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h0);
    cyc(1, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 32'hFFFF_FFFF, 1, 32'h0);
    check("late_ack_valid", {31'd0, inst_valid}, 32'd0);
    check("late_ack_addr", imem_addr, RST_PC);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r, a, rdy;
      logic [31:0] np;
      int          sel;
      r   = ($urandom_range(0, 99) == 0) || (m_phase == 3 && $urandom_range(0, 3) == 0);
      a   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 5);
      sel = $urandom_range(0, 49);
      if (sel == 0)      np = m_pc + 32'd2;
      else if (sel < 8)  np = m_pc + ($urandom_range(0, 63) << 2);
      else               np = m_pc + 32'd4;
      cyc(r, a, $urandom, rdy, np);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
